// File: rtl/mem_bist_if.sv
// Valid/ready bus between the BIST controller (master) and the single-port
// memory it exercises (slave). One access per cycle; read data and ready
// are returned by the memory in the cycle after a read is issued.
interface mem_bist_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  mem_valid;
  logic                  mem_wr_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_valid, mem_wr_rd, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_wr_rd, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: on start, writes a selectable pattern to every
// address, reads every address back, compares against the expected pattern
// one cycle after each read issue, and reports pass / error count / first
// failing address.
// Optional feature: define MEM_BIST_INVERT_EN to run a second
// write/read/check pass with the inverted pattern; errors accumulate.
module mem_bist_ctrl #(
  parameter int          WIDTH      = 8,
  parameter int          DEPTH      = 16,
  parameter int          ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned SEED       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [1:0]            pat_sel,
  mem_bist_if.master            mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic [1:0]            pat_q;      // pattern captured at start
  logic                  inv_q;      // second (inverted) pass active
  logic                  cmp_q;      // a read was issued last cycle
  logic [WIDTH-1:0]      exp_q;      // expected data for that read
  logic [ADDR_WIDTH-1:0] addr_q;     // address of that read
  logic [WIDTH-1:0]      pat_cur;
  logic                  err_hit;

  // Pattern generator; the address is zero-extended or truncated to WIDTH.
  function automatic logic [WIDTH-1:0] pat_fn(input logic [1:0] sel,
                                              input logic [ADDR_WIDTH-1:0] a);
    logic [WIDTH-1:0] chk;
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) chk[i] = (i % 2 == 0);
    if (a[0]) chk = ~chk;
    case (sel)
      2'd0:    p = WIDTH'(a);
      2'd1:    p = chk;
      2'd2:    p = '1;
      default: p = WIDTH'(SEED) ^ WIDTH'(a);
    endcase
    return p;
  endfunction

  assign pat_cur = inv_q ? ~pat_fn(pat_q, cnt) : pat_fn(pat_q, cnt);
  assign err_hit = cmp_q && (!mem.mem_ready || (mem.mem_rdata != exp_q));
  assign busy    = (state == WRITE) || (state == READ) || (state == CHECK);
  assign done    = (state == DONE);

  // State register, counter, read-compare pipeline and result registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= IDLE;
      cnt       <= '0;
      pat_q     <= '0;
      inv_q     <= 1'b0;
      cmp_q     <= 1'b0;
      exp_q     <= '0;
      addr_q    <= '0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cmp_q  <= (state == READ);
      exp_q  <= (state == READ) ? pat_cur : '0;
      addr_q <= (state == READ) ? cnt : '0;

      if (state == IDLE && start) begin
        pat_q     <= pat_sel;
        inv_q     <= 1'b0;
        pass      <= 1'b0;
        err_count <= '0;
        fail_addr <= '0;
      end

`ifdef MEM_BIST_INVERT_EN
      if (state == CHECK && !inv_q) inv_q <= 1'b1;
`endif

      // Only the first mismatch records its address; the count saturates.
      if (err_hit) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) fail_addr <= addr_q;
      end

      // The final compare happens in the same cycle, so fold it in here.
      if (state == CHECK && state_nxt == DONE)
        pass <= (err_count == '0) && !err_hit;
    end
  end

  // Next-state, counter and bus drive.
  // NOTE: every output of this block is defaulted first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mem.mem_valid = 1'b0;
    mem.mem_wr_rd = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WRITE;
          cnt_nxt   = '0;
        end
      end
      WRITE: begin
        mem.mem_valid = 1'b1;
        mem.mem_wr_rd = 1'b1;
        mem.mem_addr  = cnt;
        mem.mem_wdata = pat_cur;
        if (cnt == LAST) begin
          state_nxt = READ;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      READ: begin
        mem.mem_valid = 1'b1;
        mem.mem_addr  = cnt;
        if (cnt == LAST) begin
          state_nxt = CHECK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CHECK: begin
`ifdef MEM_BIST_INVERT_EN
        state_nxt = inv_q ? DONE : WRITE;
`else
        state_nxt = DONE;
`endif
        cnt_nxt = '0;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Upstream master for the team's single-port valid/ready memory: drives addr, wr_rd, wdata and valid, and consumes rdata and ready.
- On a start pulse, writes a selectable pattern to every address, reads every address back, compares the data and reports a pass/fail summary.
- Used for power-on self-test and bring-up of the memory instance it drives.

Parameters:
- WIDTH, 8, data width; must match the memory.
- DEPTH, 16, number of words tested.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- SEED, 8'hA5, constant for pattern 3; truncated or zero-extended to WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- res  input  1  reset, asynchronous, active-high.
- start  input  1  begin test; sampled only in IDLE.
- pat_sel  input  2  pattern select; captured when start is accepted.
- mem_rdata  input  WIDTH  read data from the memory.
- mem_ready  input  1  ready from the memory.
- mem_valid  output  1  access request.
- mem_wr_rd  output  1  1 = write, 0 = read.
- mem_addr  output  ADDR_WIDTH  access address.
- mem_wdata  output  WIDTH  write data.
- busy  output  1  test in progress.
- done  output  1  one-cycle completion pulse.
- pass  output  1  last test had zero errors.
- err_count  output  ADDR_WIDTH+2  mismatches, saturating at all-ones.
- fail_addr  output  ADDR_WIDTH  address of the first mismatch.

Behaviour:
- Reset (async, res=1): state IDLE. Every output is 0, including pass, err_count and fail_addr. The counter and the captured pattern are cleared.
- States: IDLE -> WRITE -> READ -> CHECK -> DONE -> IDLE.
- IDLE: start=1 at an edge captures pat_sel, clears err_count/fail_addr/pass, sets busy, goes to WRITE with cnt=0. Start is ignored outside IDLE.
- WRITE: mem_valid=1, mem_wr_rd=1, mem_addr=cnt, mem_wdata=pat(cnt). cnt increments every cycle. At cnt=DEPTH-1 go to READ with cnt=0. One access per cycle; ready is not waited on.
- READ: mem_valid=1, mem_wr_rd=0, mem_addr=cnt. The expected value pat(cnt) and cnt are delayed one cycle. A compare is performed in the cycle after each issue. At cnt=DEPTH-1 go to CHECK.
- CHECK: mem_valid=0. Performs the final compare.
- Compare (in READ from the second read cycle onward, and in CHECK) is an error if mem_ready=0 or mem_rdata != the delayed expected value.
  - On error, err_count increments, saturating at all-ones.
  - On the first error only, fail_addr takes the delayed address.
- DONE: done=1 for one cycle, busy=0, pass=(err_count==0). Then IDLE. pass, err_count and fail_addr hold until the next accepted start or reset.
- Latency: with start sampled in cycle 0, writes occupy cycles 1..DEPTH, reads DEPTH+1..2*DEPTH, CHECK is cycle 2*DEPTH+1, and done is in cycle 2*DEPTH+2 (cycle 34 for DEPTH=16).
- Patterns: pat(a) is computed on the cnt/address value.
  - 0: a zero-extended or truncated to WIDTH.
  - 1: checkerboard; even a = ...0101 (LSB 1), odd a = the bitwise inverse.
  - 2: all ones.
  - 3: SEED ^ a.
- mem_wdata = 0 whenever mem_wr_rd=0 or mem_valid=0. mem_addr = 0 outside WRITE and READ.
- Reset mid-operation aborts immediately to IDLE with all outputs 0. No done pulse is produced.
- cnt wraps are impossible by construction. DEPTH need not be a power of 2; the terminal compare is against DEPTH-1.

Optional Feature:
- Macro MEM_BIST_INVERT_EN.
- Defined: after CHECK, a second WRITE/READ/CHECK pass runs using ~pat(a). done comes in cycle 4*DEPTH+3 (with start sampled in cycle 0). err_count accumulates across both passes. fail_addr is the first failing address of either pass.
- Undefined: single pass only, as described above.

Test Plan:
- DEPTH=16, pat_sel=0, ideal memory model -> writes addr 0..15 with data 0..15, done in cycle 34, pass=1, err_count=0, fail_addr=0.
- pat_sel=2, model with bit0 of addr 5 stuck at 0 -> reads 8'hFE at addr 5, err_count=1, fail_addr=5, pass=0.
- pat_sel=1, model forcing mem_ready=0 during reads of addr 3 and 9 -> err_count=2, fail_addr=3.
- res asserted mid-WRITE at cycle 7 -> mem_valid, busy and done are 0 immediately without a clock. A fresh start then completes with done at cycle 34 relative to the new start.
- start pulsed again at cycle 10 during a test -> ignored; single done at cycle 34. pat_sel changed mid-test has no effect.
- MEM_BIST_INVERT_EN defined, pat_sel=3 -> second pass writes ~(8'hA5^a), done in cycle 67, pass=1.
